// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int SEL_W_DEF  = DATA_W_DEF / 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_D_BUSY = 2'd1,
    ARB_I_BUSY = 2'd2
  } arb_state_e;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the fetch port, data port and external memory port of the arbiter.
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = DATA_W / 8
);
  logic              ibus_req_i;
  logic [ADDR_W-1:0] ibus_addr_i;
  logic [DATA_W-1:0] ibus_rdata_o;
  logic              ibus_ack_o;
  logic              ibus_stall_o;
  logic              flush_i;

  logic              dbus_req_i;
  logic              dbus_we_i;
  logic [SEL_W-1:0]  dbus_sel_i;
  logic [ADDR_W-1:0] dbus_addr_i;
  logic [DATA_W-1:0] dbus_wdata_i;
  logic [DATA_W-1:0] dbus_rdata_o;
  logic              dbus_ack_o;
  logic              dbus_stall_o;

  logic              mem_ce_o;
  logic              mem_we_o;
  logic [SEL_W-1:0]  mem_sel_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ready_i;

  // Arbiter side.
  modport slave (
    input  ibus_req_i, ibus_addr_i, flush_i,
    output ibus_rdata_o, ibus_ack_o, ibus_stall_o,
    input  dbus_req_i, dbus_we_i, dbus_sel_i, dbus_addr_i, dbus_wdata_i,
    output dbus_rdata_o, dbus_ack_o, dbus_stall_o,
    output mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ready_i
  );

  // Core plus memory side.
  modport master (
    output ibus_req_i, ibus_addr_i, flush_i,
    input  ibus_rdata_o, ibus_ack_o, ibus_stall_o,
    output dbus_req_i, dbus_we_i, dbus_sel_i, dbus_addr_i, dbus_wdata_i,
    input  dbus_rdata_o, dbus_ack_o, dbus_stall_o,
    input  mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ready_i
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data has fixed priority; a fetch cancelled by flush completes silently.
//
// state      | meaning
// ARB_IDLE   | no access; grant data first, else fetch (unless flushed)
// ARB_D_BUSY | data access on memory, waiting for mem_ready_i
// ARB_I_BUSY | fetch on memory, waiting for mem_ready_i (discard = flushed)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = DATA_W / 8
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.slave   bus
);

  arb_state_e        state;
  logic              discard;
  logic              ce_q;
  logic              we_q;
  logic [SEL_W-1:0]  sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_hold;
  logic [DATA_W-1:0] d_hold;
  logic              d_ack;
  logic              i_ack;
  logic              i_discarding;

  // Completion decode: a flushed fetch never acknowledges.
  always_comb begin
    d_ack        = (state == ARB_D_BUSY) && bus.mem_ready_i;
    i_ack        = (state == ARB_I_BUSY) && bus.mem_ready_i && !discard && !bus.flush_i;
    i_discarding = (state == ARB_I_BUSY) && discard;
  end

  assign bus.dbus_ack_o   = d_ack;
  assign bus.ibus_ack_o   = i_ack;
  assign bus.dbus_rdata_o = d_ack ? bus.mem_rdata_i : d_hold;
  assign bus.ibus_rdata_o = i_ack ? bus.mem_rdata_i : i_hold;
  assign bus.dbus_stall_o = bus.dbus_req_i && !d_ack;
  assign bus.ibus_stall_o = bus.ibus_req_i && !i_ack && !bus.flush_i && !i_discarding;

  assign bus.mem_ce_o    = ce_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_sel_o   = sel_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

  // Arbitration FSM with registered memory-side outputs and read-data holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ARB_IDLE;
      discard <= 1'b0;
      ce_q    <= CHIP_DISABLE;
      we_q    <= WRITE_DISABLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      i_hold  <= '0;
      d_hold  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (bus.dbus_req_i) begin
            ce_q    <= CHIP_ENABLE;
            we_q    <= bus.dbus_we_i;
            sel_q   <= bus.dbus_sel_i;
            addr_q  <= bus.dbus_addr_i;
            wdata_q <= bus.dbus_wdata_i;
            state   <= ARB_D_BUSY;
          end else if (bus.ibus_req_i && !bus.flush_i) begin
            ce_q    <= CHIP_ENABLE;
            we_q    <= WRITE_DISABLE;
            sel_q   <= '1;
            addr_q  <= bus.ibus_addr_i;
            discard <= 1'b0;
            state   <= ARB_I_BUSY;
          end
        end
        ARB_D_BUSY: begin
          if (bus.mem_ready_i) begin
            d_hold <= bus.mem_rdata_i;
            ce_q   <= CHIP_DISABLE;
            we_q   <= WRITE_DISABLE;
            state  <= ARB_IDLE;
          end
        end
        ARB_I_BUSY: begin
          if (bus.mem_ready_i) begin
            if (!discard && !bus.flush_i) begin
              i_hold <= bus.mem_rdata_i;
            end
            discard <= 1'b0;
            ce_q    <= CHIP_DISABLE;
            we_q    <= WRITE_DISABLE;
            state   <= ARB_IDLE;
          end else if (bus.flush_i) begin
            discard <= 1'b1;
          end
        end
        default: begin
          ce_q  <= CHIP_DISABLE;
          we_q  <= WRITE_DISABLE;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter. Expected grant order
// comes from the priority rule applied to a list of pending requests.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  logic        e_we;
  logic [3:0]  e_sel;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic [31:0] last_i;
  logic [31:0] last_d;

  typedef struct {
    bit          is_d;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t pending[$];

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Advance until mem_ce_o rises; every grant here is due one edge later.
  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.mem_ce_o !== 1'b1 && n < 8);
    check({tag, " grant latency"}, 32'(n), 32'd1);
  endtask

  // Entered in the first granted cycle; completes the access after lat wait cycles.
  task automatic do_access(input bit is_d, input int lat, input logic [31:0] rd, input string tag);
    bit other_waiting;
    check({tag, " mem_we"},   {31'd0, bus.mem_we_o}, {31'd0, e_we});
    check({tag, " mem_sel"},  {28'd0, bus.mem_sel_o}, {28'd0, e_sel});
    check({tag, " mem_addr"}, bus.mem_addr_o, e_addr);
    if (is_d) check({tag, " mem_wdata"}, bus.mem_wdata_o, e_wdata);
    other_waiting = is_d && (bus.ibus_req_i === 1'b1);
    for (int k = 0; k < lat; k++) begin
      #1;
      if (is_d) begin
        check({tag, " dstall wait"}, {31'd0, bus.dbus_stall_o}, 32'd1);
        check({tag, " dack wait"},   {31'd0, bus.dbus_ack_o},   32'd0);
      end else begin
        check({tag, " istall wait"}, {31'd0, bus.ibus_stall_o}, 32'd1);
        check({tag, " iack wait"},   {31'd0, bus.ibus_ack_o},   32'd0);
      end
      check({tag, " ce held"}, {31'd0, bus.mem_ce_o}, 32'd1);
      tick();
    end
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = rd;
    #1;
    if (is_d) begin
      check({tag, " dack"},   {31'd0, bus.dbus_ack_o},   32'd1);
      check({tag, " drdata"}, bus.dbus_rdata_o, rd);
      check({tag, " dstall"}, {31'd0, bus.dbus_stall_o}, 32'd0);
      check({tag, " no iack"}, {31'd0, bus.ibus_ack_o}, 32'd0);
      if (other_waiting) check({tag, " istall"}, {31'd0, bus.ibus_stall_o}, 32'd1);
    end else begin
      check({tag, " iack"},   {31'd0, bus.ibus_ack_o},   32'd1);
      check({tag, " irdata"}, bus.ibus_rdata_o, rd);
      check({tag, " istall"}, {31'd0, bus.ibus_stall_o}, 32'd0);
      check({tag, " no dack"}, {31'd0, bus.dbus_ack_o}, 32'd0);
    end
    tick();
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = $urandom;
    if (is_d) begin
      bus.dbus_req_i = 1'b0;
      last_d = rd;
    end else begin
      bus.ibus_req_i = 1'b0;
      last_i = rd;
    end
    #1;
    check({tag, " idle ce"}, {31'd0, bus.mem_ce_o}, 32'd0);
    check({tag, " idle we"}, {31'd0, bus.mem_we_o}, 32'd0);
    check({tag, " hold drdata"}, bus.dbus_rdata_o, last_d);
    check({tag, " hold irdata"}, bus.ibus_rdata_o, last_i);
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    e_we = 1'b0; e_sel = 4'hF; e_addr = a; e_wdata = 32'd0;
  endtask

  task automatic expect_data(input logic we, input logic [3:0] s, input logic [31:0] a, input logic [31:0] w);
    e_we = we; e_sel = s; e_addr = a; e_wdata = w;
  endtask

  initial begin
    total = 0; passed = 0;
    last_i = 32'd0; last_d = 32'd0;
    rst = 1'b0;
    bus.ibus_req_i = 1'b1; bus.ibus_addr_i = 32'd0; bus.flush_i = 1'b0;
    bus.dbus_req_i = 1'b1; bus.dbus_we_i = 1'b0; bus.dbus_sel_i = 4'h0;
    bus.dbus_addr_i = 32'd0; bus.dbus_wdata_i = 32'd0;
    bus.mem_rdata_i = 32'd0; bus.mem_ready_i = 1'b0;

    // Reset state.
    #3;
    check("rst ce",     {31'd0, bus.mem_ce_o}, 32'd0);
    check("rst we",     {31'd0, bus.mem_we_o}, 32'd0);
    check("rst sel",    {28'd0, bus.mem_sel_o}, 32'd0);
    check("rst addr",   bus.mem_addr_o, 32'd0);
    check("rst wdata",  bus.mem_wdata_o, 32'd0);
    check("rst iack",   {31'd0, bus.ibus_ack_o}, 32'd0);
    check("rst dack",   {31'd0, bus.dbus_ack_o}, 32'd0);
    check("rst istall", {31'd0, bus.ibus_stall_o}, 32'd1);
    check("rst dstall", {31'd0, bus.dbus_stall_o}, 32'd1);
    check("rst irdata", bus.ibus_rdata_o, 32'd0);
    check("rst drdata", bus.dbus_rdata_o, 32'd0);
    bus.ibus_req_i = 1'b0; bus.dbus_req_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Plain fetch, ready two cycles after grant.
    bus.ibus_req_i = 1'b1; bus.ibus_addr_i = 32'h0000_0004;
    #1;
    check("t1 stall pre", {31'd0, bus.ibus_stall_o}, 32'd1);
    check("t1 ce pre",    {31'd0, bus.mem_ce_o}, 32'd0);
    wait_grant("t1");
    expect_fetch(32'h0000_0004);
    do_access(1'b0, 2, 32'h3401_1100, "t1");

    // Simultaneous requests: data first, fetch after one idle cycle.
    bus.dbus_req_i = 1'b1; bus.dbus_we_i = 1'b1; bus.dbus_sel_i = 4'h3;
    bus.dbus_addr_i = 32'h0000_0100; bus.dbus_wdata_i = 32'hDEAD_BEEF;
    bus.ibus_req_i = 1'b1; bus.ibus_addr_i = 32'h0000_0008;
    wait_grant("t2 d");
    expect_data(1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF);
    do_access(1'b1, 1, 32'h0, "t2 d");
    wait_grant("t2 i");
    expect_fetch(32'h0000_0008);
    do_access(1'b0, 0, 32'hA5A5_0008, "t2 i");

    // Flush one cycle before ready: fetch discarded, then refetched.
    bus.ibus_req_i = 1'b1; bus.ibus_addr_i = 32'h0000_0010;
    wait_grant("t3");
    bus.flush_i = 1'b1;
    #1;
    check("t3 stall flush", {31'd0, bus.ibus_stall_o}, 32'd0);
    check("t3 ack flush",   {31'd0, bus.ibus_ack_o}, 32'd0);
    tick();
    bus.flush_i = 1'b0;
    #1;
    check("t3 stall discard", {31'd0, bus.ibus_stall_o}, 32'd0);
    bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'hBAD0_0001;
    #1;
    check("t3 no ack",   {31'd0, bus.ibus_ack_o}, 32'd0);
    check("t3 rdata kept", bus.ibus_rdata_o, last_i);
    tick();
    bus.mem_ready_i = 1'b0;
    #1;
    check("t3 idle ce",   {31'd0, bus.mem_ce_o}, 32'd0);
    check("t3 rdata held", bus.ibus_rdata_o, last_i);
    check("t3 stall again", {31'd0, bus.ibus_stall_o}, 32'd1);
    wait_grant("t3 refetch");
    expect_fetch(32'h0000_0010);
    do_access(1'b0, 1, 32'h0000_1111, "t3 refetch");

    // Flush coincident with ready, then flush blocking a grant in idle.
    bus.ibus_req_i = 1'b1; bus.ibus_addr_i = 32'h0000_0020;
    wait_grant("t4");
    bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'hBAD0_0002; bus.flush_i = 1'b1;
    #1;
    check("t4 ack suppressed", {31'd0, bus.ibus_ack_o}, 32'd0);
    check("t4 rdata kept",     bus.ibus_rdata_o, last_i);
    tick();
    bus.mem_ready_i = 1'b0; bus.flush_i = 1'b0; bus.ibus_req_i = 1'b0;
    #1;
    check("t4 idle ce",    {31'd0, bus.mem_ce_o}, 32'd0);
    check("t4 rdata held", bus.ibus_rdata_o, last_i);
    bus.ibus_req_i = 1'b1; bus.ibus_addr_i = 32'h0000_0024; bus.flush_i = 1'b1;
    tick();
    #1;
    check("t4 flush blocks grant", {31'd0, bus.mem_ce_o}, 32'd0);
    bus.flush_i = 1'b0;
    wait_grant("t4 after flush");
    expect_fetch(32'h0000_0024);
    do_access(1'b0, 0, 32'h0000_2424, "t4 fetch");

    // Load with ready in the first grant cycle.
    bus.dbus_req_i = 1'b1; bus.dbus_we_i = 1'b0; bus.dbus_sel_i = 4'hF;
    bus.dbus_addr_i = 32'h0000_0200; bus.dbus_wdata_i = 32'h0;
    wait_grant("t5");
    expect_data(1'b0, 4'hF, 32'h0000_0200, 32'h0);
    do_access(1'b1, 0, 32'h1234_5678, "t5");

    // Reset in the middle of a data access.
    bus.dbus_req_i = 1'b1; bus.dbus_we_i = 1'b1; bus.dbus_sel_i = 4'hC;
    bus.dbus_addr_i = 32'h0000_0300; bus.dbus_wdata_i = 32'hCAFE_F00D;
    wait_grant("t6");
    bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'h5555_AAAA;
    rst = 1'b0;
    #1;
    check("t6 ce async", {31'd0, bus.mem_ce_o}, 32'd0);
    check("t6 no ack",   {31'd0, bus.dbus_ack_o}, 32'd0);
    check("t6 stall",    {31'd0, bus.dbus_stall_o}, 32'd1);
    check("t6 drdata cleared", bus.dbus_rdata_o, 32'd0);
    bus.mem_ready_i = 1'b0;
    tick();
    check("t6 ce in reset", {31'd0, bus.mem_ce_o}, 32'd0);
    rst = 1'b1;
    last_d = 32'd0; last_i = 32'd0;
    wait_grant("t6 regrant");
    expect_data(1'b1, 4'hC, 32'h0000_0300, 32'hCAFE_F00D);
    do_access(1'b1, 1, 32'h0, "t6 regrant");

    // Randomized traffic: pending list ordered by data-first priority.
    for (int it = 0; it < 16; it++) begin
      int   mode;
      req_t r;
      mode = int'($urandom_range(0, 2));
      pending.delete();
      if (mode != 0) begin
        r.is_d  = 1'b1;
        r.we    = 1'($urandom_range(0, 1));
        r.sel   = 4'($urandom_range(1, 15));
        r.addr  = {$urandom, 2'b00} & 32'h0000_FFFC;
        r.wdata = $urandom;
        pending.push_back(r);
        bus.dbus_req_i = 1'b1; bus.dbus_we_i = r.we; bus.dbus_sel_i = r.sel;
        bus.dbus_addr_i = r.addr; bus.dbus_wdata_i = r.wdata;
      end
      if (mode != 1) begin
        r.is_d  = 1'b0;
        r.we    = 1'b0;
        r.sel   = 4'hF;
        r.addr  = ({$urandom, 2'b00} & 32'h0000_FFFC) | 32'h0001_0000;
        r.wdata = 32'd0;
        pending.push_back(r);
        bus.ibus_req_i = 1'b1; bus.ibus_addr_i = r.addr;
      end
      while (pending.size() > 0) begin
        r = pending.pop_front();
        wait_grant($sformatf("rnd%0d", it));
        if (r.is_d) expect_data(r.we, r.sel, r.addr, r.wdata);
        else        expect_fetch(r.addr);
        do_access(r.is_d, int'($urandom_range(0, 3)), $urandom, $sformatf("rnd%0d", it));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
